// File: rtl/dm_access_arbiter_if.sv
// Bus bundle between the two requesters, the data memory port and the arbiter.
interface dm_access_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p_req;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              p_ack;
  logic [DATA_W-1:0] p_rdata;

  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_ack;
  logic [DATA_W-1:0] c_rdata;

  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              busy;

  // Arbiter view
  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    input  c_req, c_we, c_addr, c_wdata,
    input  dm_rdata,
    output p_ack, p_rdata, c_ack, c_rdata,
    output dm_wr, dm_addr, dm_wdata, busy
  );

  // Requester/memory environment view
  modport master (
    output p_req, p_we, p_addr, p_wdata,
    output c_req, c_we, c_addr, c_wdata,
    output dm_rdata,
    input  p_ack, p_rdata, c_ack, c_rdata,
    input  dm_wr, dm_addr, dm_wdata, busy
  );
endinterface

// File: rtl/dm_access_arbiter.sv
// Shares the data memory port between the pipeline (p_*) and comp (c_*)
// requesters. Each transaction runs IDLE -> SERVE -> ACK with registered
// memory controls and a one-cycle ack carrying the captured read data.
module dm_access_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 3
) (
  input  logic               clk,
  input  logic               reset,
  dm_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SERVE, ST_ACK} state_t;

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_owner_c;
  logic              r_last_c;
  logic [3:0]        r_c_wait;
  logic              r_dm_wr;
  logic [ADDR_W-1:0] r_dm_addr;
  logic [DATA_W-1:0] r_dm_wdata;
  logic              r_p_ack;
  logic              r_c_ack;
  logic [DATA_W-1:0] r_p_rdata;
  logic [DATA_W-1:0] r_c_rdata;

  logic              w_any_req;
  logic              w_grant_c;
  logic [3:0]        w_c_wait_nxt;

  assign bus.dm_wr    = r_dm_wr;
  assign bus.dm_addr  = r_dm_addr;
  assign bus.dm_wdata = r_dm_wdata;
  assign bus.p_ack    = r_p_ack;
  assign bus.c_ack    = r_c_ack;
  assign bus.p_rdata  = r_p_rdata;
  assign bus.c_rdata  = r_c_rdata;
  assign bus.busy     = (r_state != ST_IDLE);

  // Next state, grant decision and comp starvation counter update
  always_comb begin
    w_next_state = r_state;
    w_any_req    = bus.p_req | bus.c_req;
    w_grant_c    = 1'b0;
    w_c_wait_nxt = r_c_wait;
    case (r_state)
      ST_IDLE: begin
        if (bus.p_req && bus.c_req) begin
          if (PRIO_MODE == 0) w_grant_c = ~r_last_c;
          else                w_grant_c = (r_c_wait == LP_MAX_WAIT);
        end else begin
          w_grant_c = bus.c_req;
        end
        if (!bus.c_req || w_grant_c) w_c_wait_nxt = '0;
        else if (r_c_wait != 4'hF)   w_c_wait_nxt = r_c_wait + 4'd1;
        if (w_any_req) w_next_state = ST_SERVE;
      end
      ST_SERVE: w_next_state = ST_ACK;
      ST_ACK:   w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Latch the winner's request, drive memory, capture read data and ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner_c  <= 1'b0;
      r_last_c   <= 1'b1;
      r_c_wait   <= '0;
      r_dm_wr    <= 1'b0;
      r_dm_addr  <= '0;
      r_dm_wdata <= '0;
      r_p_ack    <= 1'b0;
      r_c_ack    <= 1'b0;
      r_p_rdata  <= '0;
      r_c_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_c_wait <= w_c_wait_nxt;
          if (w_any_req) begin
            r_owner_c  <= w_grant_c;
            r_last_c   <= w_grant_c;
            r_dm_wr    <= w_grant_c ? bus.c_we    : bus.p_we;
            r_dm_addr  <= w_grant_c ? bus.c_addr  : bus.p_addr;
            r_dm_wdata <= w_grant_c ? bus.c_wdata : bus.p_wdata;
          end else begin
            r_dm_wr <= 1'b0;
          end
        end
        ST_SERVE: begin
          r_dm_wr <= 1'b0;
          if (r_owner_c) begin
            r_c_rdata <= bus.dm_rdata;
            r_c_ack   <= 1'b1;
          end else begin
            r_p_rdata <= bus.dm_rdata;
            r_p_ack   <= 1'b1;
          end
        end
        ST_ACK: begin
          r_p_ack <= 1'b0;
          r_c_ack <= 1'b0;
        end
        default: begin
          r_dm_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule
